pkt_fifo: RTL and testbench
===========================

PKT_FIFO -- requirements
Module: pkt_fifo

Interface
REQ-001 Parameter: AW, default 8, log2 of storage depth; DEPTH = 2^AW entries, each 9 bits (8 data plus 1 last flag).
REQ-002 clk  in  1  clock; all logic rising-edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 wr_data  in  8  byte from upstream packet writer.
REQ-005 wr_last  in  1  marks final byte of packet; qualified by wr_ena.
REQ-006 wr_ena  in  1  write strobe, one byte per cycle.
REQ-007 wr_full  out  1  storage full, including uncommitted bytes.
REQ-008 rd_data  out  8  head byte.
REQ-009 rd_last  out  1  head byte is the last byte of its packet.
REQ-010 rd_valid  out  1  head byte valid.
REQ-011 rd_ready  in  1  consumer accepts head byte.
REQ-012 pkt_avail  out  1  at least one complete packet is stored or being presented.
REQ-013 drop_stb  out  1  one-cycle pulse when a packet is discarded due to overflow.

Function
REQ-014 Pointers: wp (write), cp (commit), rp (read), each AW+1 bits; all arithmetic is modulo 2^(AW+1).
REQ-015 wr_full = ((wp - rp) == DEPTH), combinational from registered pointers.
REQ-016 Write FSM states: ACCEPT and DISCARD.
REQ-017 ACCEPT with wr_ena & !wr_full: store {wr_last, wr_data} at wp[AW-1:0], then wp++.
REQ-018 If that stored byte has wr_last=1, then cp <= wp+1 in the same edge, which commits the packet.
REQ-019 ACCEPT with wr_ena & wr_full: byte is not stored; wp <= cp (rewinds the partial packet); drop_stb=1 next cycle.
REQ-020 In the REQ-019 case, next state is DISCARD if wr_last=0, otherwise remain in ACCEPT.
REQ-021 DISCARD: all writes ignored and wp unchanged; wr_ena & wr_last returns the FSM to ACCEPT; the next byte starts a new packet.
REQ-022 Readers never see uncommitted bytes: a byte is readable only when rp != cp.
REQ-023 Read side is show-ahead with one output register: rd_valid/rd_data/rd_last registered.
REQ-024 Storage read uses a 1-cycle synchronous RAM (SB_RAM-compatible).
REQ-025 Pop occurs when rd_valid & rd_ready: on that edge the output register is reloaded from the next entry or cleared, with no bubble when data is available.
REQ-026 Latency: a commit edge at cycle N into an empty FIFO gives rd_valid=1 at cycle N+2.
REQ-027 rd_valid stays high and rd_data/rd_last stay stable until popped.
REQ-028 Packet counter pc (AW+1 bits): +1 on commit; -1 on pop of a byte with rd_last=1; unchanged on simultaneous commit and last-pop.
REQ-029 pkt_avail = (pc != 0).
REQ-030 A simultaneous write and pop in the same cycle are both honoured; wr_full is evaluated on pre-edge pointers.
REQ-031 A packet larger than DEPTH can never commit; it is always dropped per REQ-019.

Reset
REQ-032 On rst, these registers clear to 0: wp, cp, rp, pc; FSM=ACCEPT; rd_valid=0, rd_data=0, rd_last=0, drop_stb=0.
REQ-033 RAM contents are not cleared.
REQ-034 Reset mid-packet or mid-read discards all content; first cycle after rst deasserts: wr_full=0, pkt_avail=0.

Verification
REQ-035 Write 3 bytes A5,01,02 (last on 02), rd_ready=1 -> rd_valid at commit+2; outputs A5,01,02 on consecutive cycles; rd_last only on 02; pkt_avail 1 -> 0 after 02 popped.
REQ-036 Write 2 bytes without last, hold 10 cycles -> rd_valid=0 and pkt_avail=0 throughout; write last byte -> rd_valid rises 2 cycles later.
REQ-037 AW=2, rd_ready=0, write 6-byte packet -> wr_full after byte 4; byte 5 triggers drop_stb pulse and DISCARD; wp returns to 0; after last, write 2-byte packet -> it reads out intact.
REQ-038 Fill with two 2-byte packets (AW=2); pop and write on same cycles -> no loss or duplication; pc tracks 2/1/2 correctly; simultaneous commit and last-pop leaves pkt_avail=1.
REQ-039 Assert rst while rd_valid=1 and a packet is half written -> next cycle rd_valid=0, pkt_avail=0, wr_full=0; a new 1-byte packet 3C reads out as 3C with rd_last=1.
REQ-040 Run wp/rp past 2^(AW+1) with 1-byte packets -> wr_full and rd_valid stay correct across wrap.

Source files
------------

// File: rtl/pkt_fifo.sv
// pkt_fifo -- packet-aware byte FIFO with overflow drop.
//
// Bytes from an upstream writer are staged in a synchronous RAM. A packet only
// becomes visible to the reader once its last byte is stored (commit). If the
// storage fills before the last byte arrives, the partial packet is rewound and
// the rest of it is ignored.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   wr_data    byte from upstream
//   wr_last    final byte of the packet (qualified by wr_ena)
//   wr_ena     write strobe
//   wr_full    storage full, uncommitted bytes included
//   rd_data    head byte (registered)
//   rd_last    head byte ends its packet (registered)
//   rd_valid   head byte valid (registered)
//   rd_ready   consumer accepts the head byte
//   pkt_avail  at least one complete packet stored or being presented
//   drop_stb   one-cycle pulse when a packet is discarded on overflow
module pkt_fifo #(
  parameter int AW = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  input  logic       wr_ena,
  output logic       wr_full,
  output logic [7:0] rd_data,
  output logic       rd_last,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       pkt_avail,
  output logic       drop_stb
);

  localparam int          DEPTH     = 1 << AW;
  localparam logic [AW:0] PTR_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PTR_DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [0:0] {
    ACCEPT  = 1'b0,
    DISCARD = 1'b1
  } wr_state_t;

  wr_state_t   state;
  wr_state_t   state_next;

  logic [8:0]  mem [DEPTH];
  logic [8:0]  ram_q;
  logic        ram_valid;

  logic [AW:0] wp;
  logic [AW:0] cp;
  logic [AW:0] rp;
  logic [AW:0] pc;
  logic [AW:0] wp_next;
  logic [AW:0] cp_next;

  logic        do_write;
  logic        commit;
  logic        drop_next;
  logic        pop;
  logic        pop_last;
  logic        out_load;
  logic        ram_re;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign wr_full   = ((wp - rp) == PTR_DEPTH);
  assign pkt_avail = (pc != PTR_ZERO);

  // Read pipeline: RAM stage (ram_q) feeds the output register. The output
  // register takes ram_q whenever it is empty or being popped; the RAM stage
  // fetches a new committed entry whenever it is empty or handing off.
  assign pop      = rd_valid & rd_ready;
  assign pop_last = pop & rd_last;
  assign out_load = ram_valid & (~rd_valid | pop);
  assign ram_re   = (rp != cp) & (~ram_valid | out_load);

  // Write FSM next state, pointer updates and drop detection
  always_comb begin
    state_next = state;
    wp_next    = wp;
    cp_next    = cp;
    do_write   = 1'b0;
    commit     = 1'b0;
    drop_next  = 1'b0;
    case (state)
      ACCEPT: begin
        if (wr_ena) begin
          if (!wr_full) begin
            do_write = 1'b1;
            wp_next  = wp + PTR_ONE;
            if (wr_last) begin
              cp_next = wp + PTR_ONE;
              commit  = 1'b1;
            end else begin
              cp_next = cp;
            end
          end else begin
            // Overflow: throw away everything written since the last commit.
            wp_next   = cp;
            drop_next = 1'b1;
            if (wr_last) begin
              state_next = ACCEPT;
            end else begin
              state_next = DISCARD;
            end
          end
        end else begin
          state_next = ACCEPT;
        end
      end
      DISCARD: begin
        if (wr_ena && wr_last) begin
          state_next = ACCEPT;
        end else begin
          state_next = DISCARD;
        end
      end
      default: begin
        state_next = ACCEPT;
      end
    endcase
  end

  // Write FSM state, write/commit pointers and drop strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCEPT;
      wp       <= PTR_ZERO;
      cp       <= PTR_ZERO;
      drop_stb <= 1'b0;
    end else begin
      state    <= state_next;
      wp       <= wp_next;
      cp       <= cp_next;
      drop_stb <= drop_next;
    end
  end

  // RAM write port; contents are deliberately left uncleared by reset
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wp[AW-1:0]] <= {wr_last, wr_data};
    end
  end

  // RAM read port; output holds its value while no read is issued
  always_ff @(posedge clk) begin
    if (ram_re) begin
      ram_q <= mem[rp[AW-1:0]];
    end
  end

  // Read pointer and RAM-stage occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rp        <= PTR_ZERO;
      ram_valid <= 1'b0;
    end else begin
      if (ram_re) begin
        rp <= rp + PTR_ONE;
      end
      ram_valid <= ram_re | (ram_valid & ~out_load);
    end
  end

  // Show-ahead output register
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
      rd_last  <= 1'b0;
    end else if (out_load) begin
      rd_valid <= 1'b1;
      rd_data  <= ram_q[7:0];
      rd_last  <= ram_q[8];
    end else if (pop) begin
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
      rd_last  <= 1'b0;
    end
  end

  // Complete-packet counter; a commit and a last-byte pop cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= PTR_ZERO;
    end else begin
      case ({commit, pop_last})
        2'b10:   pc <= pc + PTR_ONE;
        2'b01:   pc <= pc - PTR_ONE;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_fifo.sv
// tb_pkt_fifo -- directed self-checking bench for pkt_fifo (AW=2, DEPTH=4).
// Bytes that are expected to reach the reader are queued as they are written;
// every accepted head byte is popped from that queue and compared.
module tb_pkt_fifo;

  localparam int AW = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_last = 1'b0;
  logic       wr_ena = 1'b0;
  logic       wr_full;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic       pkt_avail;
  logic       drop_stb;

  logic [8:0] sb[$];
  int         vecs = 0;
  int         errs = 0;

  pkt_fifo #(.AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .wr_ena    (wr_ena),
    .wr_full   (wr_full),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .pkt_avail (pkt_avail),
    .drop_stb  (drop_stb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic l, input bit keep);
    wr_data = d;
    wr_last = l;
    wr_ena  = 1'b1;
    if (keep) sb.push_back({l, d});
    tick();
    wr_ena  = 1'b0;
    wr_last = 1'b0;
  endtask

  // Scoreboard: compare every byte the consumer accepts
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        vecs++;
        errs++;
        $error("FAIL pop_unexpected: observed %0h expected no data", {rd_last, rd_data});
      end else begin
        check("rd_byte", 32'({rd_last, rd_data}), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_pkt_avail", 32'(pkt_avail), 32'd0);
    check("rst_wr_full", 32'(wr_full), 32'd0);
    check("rst_drop_stb", 32'(drop_stb), 32'd0);
    rst = 1'b0;
    tick();

    // Three-byte packet, consumer always ready
    rd_ready = 1'b1;
    wr(8'hA5, 1'b0, 1'b1);
    wr(8'h01, 1'b0, 1'b1);
    wr(8'h02, 1'b1, 1'b1);
    check("t1_avail_commit", 32'(pkt_avail), 32'd1);
    check("t1_valid_n0", 32'(rd_valid), 32'd0);
    tick();
    check("t1_valid_n1", 32'(rd_valid), 32'd0);
    tick();
    check("t1_valid_n2", 32'(rd_valid), 32'd1);
    check("t1_head", 32'(rd_data), 32'hA5);
    check("t1_head_last", 32'(rd_last), 32'd0);
    tick();
    tick();
    check("t1_last_byte", 32'({rd_last, rd_data}), 32'h102);
    check("t1_avail_before", 32'(pkt_avail), 32'd1);
    tick();
    check("t1_avail_after", 32'(pkt_avail), 32'd0);
    check("t1_empty", 32'(rd_valid), 32'd0);
    check("t1_sb", 32'(sb.size()), 32'd0);

    // Uncommitted bytes stay invisible
    wr(8'h11, 1'b0, 1'b1);
    wr(8'h22, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("t2_hold_valid", 32'(rd_valid), 32'd0);
      check("t2_hold_avail", 32'(pkt_avail), 32'd0);
      tick();
    end
    wr(8'h33, 1'b1, 1'b1);
    check("t2_valid_n0", 32'(rd_valid), 32'd0);
    tick();
    check("t2_valid_n1", 32'(rd_valid), 32'd0);
    tick();
    check("t2_valid_n2", 32'(rd_valid), 32'd1);
    tick();
    tick();
    tick();
    check("t2_empty", 32'(rd_valid), 32'd0);
    check("t2_avail", 32'(pkt_avail), 32'd0);

    // Overflow drop of a 6-byte packet, then a clean 2-byte packet
    rd_ready = 1'b0;
    wr(8'hE1, 1'b0, 1'b0);
    wr(8'hE2, 1'b0, 1'b0);
    wr(8'hE3, 1'b0, 1'b0);
    check("t3_not_full3", 32'(wr_full), 32'd0);
    wr(8'hE4, 1'b0, 1'b0);
    check("t3_full4", 32'(wr_full), 32'd1);
    check("t3_no_drop_yet", 32'(drop_stb), 32'd0);
    wr(8'hE5, 1'b0, 1'b0);
    check("t3_drop_stb", 32'(drop_stb), 32'd1);
    check("t3_rewound", 32'(wr_full), 32'd0);
    wr(8'hE6, 1'b1, 1'b0);
    check("t3_drop_pulse_end", 32'(drop_stb), 32'd0);
    check("t3_avail_none", 32'(pkt_avail), 32'd0);
    check("t3_valid_none", 32'(rd_valid), 32'd0);
    wr(8'h77, 1'b0, 1'b1);
    wr(8'h88, 1'b1, 1'b1);
    check("t3_avail_new", 32'(pkt_avail), 32'd1);
    tick();
    tick();
    check("t3_valid_new", 32'(rd_valid), 32'd1);
    check("t3_head_new", 32'(rd_data), 32'h77);
    rd_ready = 1'b1;
    tick();
    tick();
    check("t3_drained", 32'(rd_valid), 32'd0);
    check("t3_sb", 32'(sb.size()), 32'd0);

    // Concurrent pop and write, packet counter tracking
    rd_ready = 1'b0;
    wr(8'hA0, 1'b0, 1'b1);
    wr(8'hA1, 1'b1, 1'b1);
    wr(8'hB0, 1'b0, 1'b1);
    wr(8'hB1, 1'b1, 1'b1);
    tick();
    check("t4_pc_two", 32'(dut.pc), 32'd2);
    check("t4_head", 32'(rd_data), 32'hA0);
    rd_ready = 1'b1;
    wr(8'hC0, 1'b0, 1'b1);
    check("t4_pc_e1", 32'(dut.pc), 32'd2);
    wr(8'hC1, 1'b1, 1'b1);
    check("t4_pc_simul", 32'(dut.pc), 32'd2);
    check("t4_avail_simul", 32'(pkt_avail), 32'd1);
    wr(8'hD0, 1'b0, 1'b1);
    wr(8'hD1, 1'b0, 1'b1);
    check("t4_pc_one", 32'(dut.pc), 32'd1);
    wr(8'hD2, 1'b1, 1'b1);
    check("t4_pc_back", 32'(dut.pc), 32'd2);
    for (int i = 0; i < 12; i++) tick();
    check("t4_drained", 32'(rd_valid), 32'd0);
    check("t4_pc_zero", 32'(dut.pc), 32'd0);
    check("t4_sb", 32'(sb.size()), 32'd0);

    // Reset while presenting data and mid-packet
    rd_ready = 1'b0;
    wr(8'h5A, 1'b1, 1'b1);
    tick();
    tick();
    check("t5_pre_valid", 32'(rd_valid), 32'd1);
    wr(8'h66, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check("t5_rst_valid", 32'(rd_valid), 32'd0);
    check("t5_rst_avail", 32'(pkt_avail), 32'd0);
    check("t5_rst_full", 32'(wr_full), 32'd0);
    rd_ready = 1'b1;
    wr(8'h3C, 1'b1, 1'b1);
    tick();
    tick();
    check("t5_new_valid", 32'(rd_valid), 32'd1);
    check("t5_new_byte", 32'({rd_last, rd_data}), 32'h13C);
    tick();
    check("t5_new_gone", 32'(rd_valid), 32'd0);

    // Streaming 1-byte packets past pointer wrap
    for (int i = 0; i < 20; i++) begin
      wr(8'h40 + 8'(i), 1'b1, 1'b1);
      check("t6_full", 32'(wr_full), 32'd0);
      if (i >= 2) check("t6_valid", 32'(rd_valid), 32'd1);
    end
    for (int i = 0; i < 6; i++) tick();
    check("t6_drained", 32'(rd_valid), 32'd0);
    check("t6_avail", 32'(pkt_avail), 32'd0);
    check("t6_sb", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
